// File: rtl/sram_like_arbiter.sv
// Two-to-one SRAM-like request arbiter (instruction fetch vs. data) with an
// in-order owner FIFO that routes each data_ok back to the requester that issued it.
module sram_like_arbiter #(
   parameter int OT_DEPTH = 4
) (
   input  logic        clk,
   input  logic        resetn,

   input  logic        inst_req,
   input  logic        inst_wr,
   input  logic [1:0]  inst_size,
   input  logic [31:0] inst_addr,
   input  logic [31:0] inst_wdata,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,

   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,

   output logic        req,
   output logic        wr,
   output logic [1:0]  size,
   output logic [31:0] addr,
   output logic [31:0] wdata,
   input  logic        addr_ok,
   input  logic        data_ok,
   input  logic [31:0] rdata,

   output logic        err
);

   localparam int PTR_W = $clog2(OT_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HOLD_I = 2'd1,
      HOLD_D = 2'd2
   } state_t;

   state_t              state_reg;
   state_t              state_next;
   logic [1:0]          dstreak_reg;
   logic [1:0]          dstreak_next;
   logic [PTR_W-1:0]    wr_ptr_reg;
   logic [PTR_W-1:0]    rd_ptr_reg;
   logic [CNT_W-1:0]    count_reg;
   logic [OT_DEPTH-1:0] owner_reg;
   logic                err_reg;

   logic grant_inst;
   logic grant_data;
   logic grantee_req;
   logic fifo_full;
   logic fifo_empty;
   logic accept;
   logic push;
   logic pop;
   logic head_owner;

   // Grantee selection: a held grant is sticky; in IDLE data wins unless
   // instruction fetch has been passed over three times in a row.
   always_comb begin
      grant_inst = 1'b0;
      grant_data = 1'b0;
      case (state_reg)
         HOLD_I:  grant_inst = 1'b1;
         HOLD_D:  grant_data = 1'b1;
         default: begin
            if (data_req && !(dstreak_reg == 2'd3 && inst_req)) begin
               grant_data = 1'b1;
            end else if (inst_req) begin
               grant_inst = 1'b1;
            end
         end
      endcase
   end

   assign grantee_req = (grant_inst & inst_req) | (grant_data & data_req);
   assign fifo_full   = (count_reg == CNT_W'(OT_DEPTH));
   assign fifo_empty  = (count_reg == '0);

   // Reset gating keeps the master request quiet even while requesters are active.
   assign req    = resetn & grantee_req & ~fifo_full;
   assign wr     = grant_data ? data_wr    : inst_wr;
   assign size   = grant_data ? data_size  : inst_size;
   assign addr   = grant_data ? data_addr  : inst_addr;
   assign wdata  = grant_data ? data_wdata : inst_wdata;
   assign accept = req & addr_ok;

   assign inst_addr_ok = accept & grant_inst;
   assign data_addr_ok = accept & grant_data;

   assign push       = accept;
   assign pop        = data_ok & ~fifo_empty;
   assign head_owner = owner_reg[rd_ptr_reg];

   assign inst_data_ok = pop & ~head_owner;
   assign data_data_ok = pop & head_owner;
   assign inst_rdata   = rdata;
   assign data_rdata   = rdata;
   assign err          = err_reg;

   always_comb begin
      state_next = IDLE;
      if (grantee_req && !accept) begin
         state_next = grant_data ? HOLD_D : HOLD_I;
      end
   end

   always_comb begin
      dstreak_next = dstreak_reg;
      if (accept) begin
         if (grant_data && inst_req) begin
            dstreak_next = (dstreak_reg == 2'd3) ? 2'd3 : dstreak_reg + 2'd1;
         end else begin
            dstreak_next = 2'd0;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg   <= IDLE;
         dstreak_reg <= 2'd0;
         err_reg     <= 1'b0;
      end else begin
         state_reg   <= state_next;
         dstreak_reg <= dstreak_next;
         if (data_ok && fifo_empty) begin
            err_reg <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         owner_reg  <= '0;
      end else begin
         if (push) begin
            owner_reg[wr_ptr_reg] <= grant_data;
            wr_ptr_reg            <= wr_ptr_reg + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_reg <= count_reg + CNT_W'(1);
            2'b01:   count_reg <= count_reg - CNT_W'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule
